// File: rtl/multicycle_controller.sv
// Multicycle instruction sequencer: fetches over a req/ack port, decodes a
// 4-bit opcode and steps through per-instruction register-file/memory cycles.
module multicycle_controller #(
    parameter int I_ADDR_W = 7,
    parameter int R_ADDR_W = 4,
    parameter int D_ADDR_W = 8,
    parameter int IR_W     = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    output logic                IM_req,
    output logic [I_ADDR_W-1:0] IM_addr,
    input  logic                IM_ack,
    input  logic [IR_W-1:0]     IM_data,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic                D_wr,
    output logic                RF_s,
    output logic                RF_W_en,
    output logic [R_ADDR_W-1:0] RF_W_addr,
    output logic [R_ADDR_W-1:0] RF_A_addr,
    output logic [R_ADDR_W-1:0] RF_B_addr,
    output logic [3:0]          ALU_sel,
    output logic [IR_W-1:0]     IR_Out,
    output logic [I_ADDR_W-1:0] PC_Out,
    output logic [3:0]          State,
    output logic [3:0]          NextState,
    output logic                Halted,
    output logic                Illegal
);

    if (IR_W != 4 + 3 * R_ADDR_W || D_ADDR_W != 2 * R_ADDR_W) begin : g_bad_params
        $error("multicycle_controller: need IR_W == 4+3*R_ADDR_W and D_ADDR_W == 2*R_ADDR_W");
    end

    localparam int R = R_ADDR_W;
    localparam logic [I_ADDR_W-1:0] PC_ONE = 1;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ALU    = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    state_t              state_q, state_d;
    logic [I_ADDR_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic                illegal_q, illegal_d;

    logic [3:0]          opcode;
    logic [R-1:0]        fld_hi, fld_mid, fld_lo;
    logic [D_ADDR_W-1:0] store_daddr, load_daddr;

    assign opcode      = ir_q[IR_W-1 -: 4];
    assign fld_hi      = ir_q[3*R-1:2*R];
    assign fld_mid     = ir_q[2*R-1:R];
    assign fld_lo      = ir_q[R-1:0];
    assign store_daddr = ir_q[2*R-1:0];
    assign load_daddr  = ir_q[3*R-1:R];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_INIT;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = S_INIT;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        IM_req    = 1'b0;
        IM_addr   = '0;
        D_addr    = '0;
        D_wr      = 1'b0;
        RF_s      = 1'b0;
        RF_W_en   = 1'b0;
        RF_W_addr = '0;
        RF_A_addr = '0;
        RF_B_addr = '0;
        ALU_sel   = 4'd0;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                // Request and address stay put until the memory acknowledges.
                IM_req  = 1'b1;
                IM_addr = pc_q;
                state_d = S_FETCH;
                if (IM_ack) begin
                    ir_d    = IM_data;
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:        state_d = S_NOOP;
                    OP_STORE:       state_d = S_STORE;
                    OP_LOAD:        state_d = S_LOAD_A;
                    OP_ADD, OP_SUB: state_d = S_ALU;
                    OP_HALT:        state_d = S_HALT;
                    default: begin
                        state_d   = S_NOOP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_NOOP: state_d = S_FETCH;
            S_LOAD_A, S_LOAD_B: begin
                // Memory data is given a full cycle to settle before the write.
                D_addr    = load_daddr;
                RF_s      = 1'b1;
                RF_W_addr = fld_lo;
                RF_W_en   = (state_q == S_LOAD_B);
                state_d   = (state_q == S_LOAD_A) ? S_LOAD_B : S_FETCH;
            end
            S_STORE: begin
                D_addr    = store_daddr;
                RF_A_addr = fld_hi;
                D_wr      = 1'b1;
                state_d   = S_FETCH;
            end
            S_ALU: begin
                RF_A_addr = fld_hi;
                RF_B_addr = fld_mid;
                RF_W_addr = fld_lo;
                RF_W_en   = 1'b1;
                ALU_sel   = (opcode == OP_SUB) ? 4'd2 : 4'd1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    assign IR_Out    = ir_q;
    assign PC_Out    = pc_q;
    assign State     = state_q;
    assign NextState = state_d;
    assign Halted    = (state_q == S_HALT);
    assign Illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model expands each
// fetched instruction into its expected per-cycle outputs.
module tb_multicycle_controller;
    localparam int IAW = 7;
    localparam int RAW = 4;
    localparam int DAW = 8;
    localparam int IRW = 16;

    localparam logic [3:0] ST_INIT = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                           ST_NOOP = 4'd3, ST_LOAD_A = 4'd4, ST_LOAD_B = 4'd5,
                           ST_STORE = 4'd6, ST_ALU = 4'd7, ST_HALT = 4'd8;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           IM_req, IM_ack;
    logic [IAW-1:0] IM_addr, PC_Out;
    logic [IRW-1:0] IM_data, IR_Out;
    logic [DAW-1:0] D_addr;
    logic           D_wr, RF_s, RF_W_en, Halted, Illegal;
    logic [RAW-1:0] RF_W_addr, RF_A_addr, RF_B_addr;
    logic [3:0]     ALU_sel, State, NextState;

    multicycle_controller #(.I_ADDR_W(IAW), .R_ADDR_W(RAW), .D_ADDR_W(DAW), .IR_W(IRW)) dut (
        .Clk(Clk), .Reset(Reset), .IM_req(IM_req), .IM_addr(IM_addr), .IM_ack(IM_ack),
        .IM_data(IM_data), .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
        .RF_W_addr(RF_W_addr), .RF_A_addr(RF_A_addr), .RF_B_addr(RF_B_addr),
        .ALU_sel(ALU_sel), .IR_Out(IR_Out), .PC_Out(PC_Out), .State(State),
        .NextState(NextState), .Halted(Halted), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0]     state;
        logic [3:0]     nxt;
        logic           im_req;
        logic [IAW-1:0] im_addr;
        logic [DAW-1:0] d_addr;
        logic           d_wr;
        logic           rf_s;
        logic           rf_w_en;
        logic [RAW-1:0] rf_w_addr;
        logic [RAW-1:0] rf_a;
        logic [RAW-1:0] rf_b;
        logic [3:0]     alu_sel;
        logic [IAW-1:0] pc;
        logic [IRW-1:0] ir;
        logic           halted;
        logic           illegal;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t act_r, exp_r;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    logic [IAW-1:0] m_pc;
    logic [IRW-1:0] m_ir;
    logic           m_illegal;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t sample();
        rec_t r;
        r.state = State;      r.nxt = NextState;   r.im_req = IM_req;  r.im_addr = IM_addr;
        r.d_addr = D_addr;    r.d_wr = D_wr;       r.rf_s = RF_s;      r.rf_w_en = RF_W_en;
        r.rf_w_addr = RF_W_addr; r.rf_a = RF_A_addr; r.rf_b = RF_B_addr; r.alu_sel = ALU_sel;
        r.pc = PC_Out;        r.ir = IR_Out;       r.halted = Halted;  r.illegal = Illegal;
        return r;
    endfunction

    function automatic rec_t quiet(input logic [3:0] s, input logic [3:0] n);
        rec_t r;
        r = '0;
        r.state = s; r.nxt = n; r.pc = m_pc; r.ir = m_ir; r.illegal = m_illegal;
        return r;
    endfunction

    function automatic rec_t obs_at(input int i);
        if (i < obs_q.size()) return obs_q[i];
        return '0;
    endfunction

    // Expand one instruction into the cycles it must produce; n = cycles after the ack edge.
    task automatic model_instr(input logic [IRW-1:0] instr, input int delay,
                               input int halt_cycles, output int n);
        rec_t r;
        int   op;
        op = int'(instr[15:12]);
        for (int i = 0; i < delay; i++) begin
            r = quiet(ST_FETCH, ST_FETCH); r.im_req = 1'b1; r.im_addr = m_pc;
            exp_q.push_back(r);
        end
        r = quiet(ST_FETCH, ST_DECODE); r.im_req = 1'b1; r.im_addr = m_pc;
        exp_q.push_back(r);
        m_ir = instr;
        m_pc = m_pc + 7'd1;
        n = 2;
        case (op)
            0: begin
                exp_q.push_back(quiet(ST_DECODE, ST_NOOP));
                exp_q.push_back(quiet(ST_NOOP, ST_FETCH));
            end
            1: begin
                exp_q.push_back(quiet(ST_DECODE, ST_STORE));
                r = quiet(ST_STORE, ST_FETCH);
                r.d_addr = instr[7:0]; r.rf_a = instr[11:8]; r.d_wr = 1'b1;
                exp_q.push_back(r);
            end
            2: begin
                exp_q.push_back(quiet(ST_DECODE, ST_LOAD_A));
                r = quiet(ST_LOAD_A, ST_LOAD_B);
                r.d_addr = instr[11:4]; r.rf_s = 1'b1; r.rf_w_addr = instr[3:0];
                exp_q.push_back(r);
                r.state = ST_LOAD_B; r.nxt = ST_FETCH; r.rf_w_en = 1'b1;
                exp_q.push_back(r);
                n = 3;
            end
            3, 4: begin
                exp_q.push_back(quiet(ST_DECODE, ST_ALU));
                r = quiet(ST_ALU, ST_FETCH);
                r.rf_a = instr[11:8]; r.rf_b = instr[7:4]; r.rf_w_addr = instr[3:0];
                r.rf_w_en = 1'b1; r.alu_sel = (op == 3) ? 4'd1 : 4'd2;
                exp_q.push_back(r);
            end
            5: begin
                exp_q.push_back(quiet(ST_DECODE, ST_HALT));
                for (int i = 0; i < halt_cycles; i++) begin
                    r = quiet(ST_HALT, ST_HALT); r.halted = 1'b1;
                    exp_q.push_back(r);
                end
                n = 1 + halt_cycles;
            end
            default: begin
                exp_q.push_back(quiet(ST_DECODE, ST_NOOP));
                m_illegal = 1'b1;
                exp_q.push_back(quiet(ST_NOOP, ST_FETCH));
            end
        endcase
    endtask

    always @(negedge Clk) begin
        if (chk_en && !Reset) begin
            act_r = sample();
            obs_q.push_back(act_r);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL queue_underrun t=%0t state act=%0d", $time, act_r.state);
            end else begin
                exp_r = exp_q.pop_front();
                if (act_r !== exp_r) begin
                    failures++;
                    $display("FAIL cycle_cmp t=%0t state act=%0d exp=%0d rec act=%h exp=%h",
                             $time, act_r.state, exp_r.state, act_r, exp_r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        chk_en = 1'b0;
        Reset = 1'b1;
        IM_ack = 1'b0;
        exp_q.delete();
        m_pc = '0; m_ir = '0; m_illegal = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        exp_q.push_back(quiet(ST_INIT, ST_FETCH));
        chk_en = 1'b1;
        check("init_state", State, ST_INIT);
        tick();
    endtask

    task automatic run_instr(input logic [IRW-1:0] instr, input int delay, input logic idle_ack,
                             input int halt_cycles, input int post_ticks);
        int n;
        obs_q.delete();
        model_instr(instr, delay, halt_cycles, n);
        for (int i = 0; i < delay; i++) begin
            IM_ack = 1'b0; IM_data = IRW'($urandom);
            tick();
        end
        IM_ack = 1'b1; IM_data = instr;
        tick();
        IM_ack = idle_ack; IM_data = IRW'($urandom);
        repeat ((post_ticks < 0) ? n : post_ticks) tick();
        if (post_ticks < 0) check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int d_wr_cnt;
        logic [3:0] op;
        IM_ack = 1'b0; IM_data = '0;
        apply_reset();
        #2;
        check("rst_state", State, ST_INIT);
        check("rst_pc", PC_Out, 0);
        check("rst_im_req", IM_req, 0);
        check("rst_illegal", Illegal, 0);
        repeat (2) @(posedge Clk);
        release_reset();

        run_instr(16'h3123, 0, 1'b1, 0, -1);
        check("add_st0", obs_at(0).state, ST_FETCH);
        check("add_st1", obs_at(1).state, ST_DECODE);
        check("add_st2", obs_at(2).state, ST_ALU);
        check("add_a", obs_at(2).rf_a, 1);
        check("add_b", obs_at(2).rf_b, 2);
        check("add_w", obs_at(2).rf_w_addr, 3);
        check("add_sel", obs_at(2).alu_sel, 1);
        check("add_wen", obs_at(2).rf_w_en, 1);
        check("add_pc", PC_Out, 1);

        run_instr(16'h2A57, 0, 1'b1, 0, -1);
        check("lda_daddr", obs_at(2).d_addr, 8'hA5);
        check("lda_rfs", obs_at(2).rf_s, 1);
        check("lda_wen", obs_at(2).rf_w_en, 0);
        check("ldb_waddr", obs_at(3).rf_w_addr, 7);
        check("ldb_wen", obs_at(3).rf_w_en, 1);

        run_instr(16'h14C8, 3, 1'b0, 0, -1);
        for (int i = 0; i < 4; i++) begin
            check("st_fetch_req", obs_at(i).im_req, 1);
            check("st_fetch_addr", obs_at(i).im_addr, 2);
        end
        check("st_daddr", obs_at(5).d_addr, 8'hC8);
        check("st_a", obs_at(5).rf_a, 4);
        d_wr_cnt = 0;
        foreach (obs_q[i]) d_wr_cnt += int'(obs_q[i].d_wr);
        check("st_dwr_once", d_wr_cnt, 1);

        run_instr(16'hF000, 1, 1'b1, 0, -1);
        check("ill_noop", obs_at(3).state, ST_NOOP);
        check("ill_flag", Illegal, 1);
        check("ill_fetch", State, ST_FETCH);

        run_instr(16'h4321, 0, 1'b0, 0, -1);
        check("sub_sel", obs_at(2).alu_sel, 2);

        while (m_pc != 7'h7F)
            run_instr({4'h0, 12'($urandom)}, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, -1);
        check("pc_top", PC_Out, 7'h7F);
        run_instr(16'h0000, 0, 1'b0, 0, -1);
        check("pc_wrap", PC_Out, 0);

        for (int k = 0; k < 8; k++) begin
            op = 4'($urandom_range(0, 4));
            run_instr({op, 12'($urandom)}, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, -1);
        end

        run_instr(16'h5000, 0, 1'b1, 6, -1);
        check("halt_flag", Halted, 1);
        check("halt_req", IM_req, 0);
        check("halt_state", State, ST_HALT);
        #1;
        apply_reset();
        #1;
        check("halt_rst_flag", Halted, 0);
        check("halt_rst_pc", PC_Out, 0);
        check("halt_rst_ir", IR_Out, 0);
        check("halt_rst_state", State, ST_INIT);
        check("halt_rst_illegal", Illegal, 0);

        release_reset();
        run_instr(16'h2A57, 0, 1'b0, 0, 2);
        check("ldb_pre_state", State, ST_LOAD_B);
        check("ldb_pre_wen", RF_W_en, 1);
        #2;
        apply_reset();
        #1;
        check("ldb_rst_wen", RF_W_en, 0);
        check("ldb_rst_state", State, ST_INIT);
        check("ldb_rst_rfs", RF_s, 0);

        release_reset();
        check("fetch_pre_req", IM_req, 1);
        #2;
        apply_reset();
        #1;
        check("fetch_rst_req", IM_req, 0);

        release_reset();
        run_instr(16'h3123, 1, 1'b0, 0, -1);
        check("final_pc", PC_Out, 1);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- I_ADDR_W, 7: instruction address width.
- R_ADDR_W, 4: register-file address width.
- D_ADDR_W, 8: data-memory address width.
- IR_W, 16: instruction width.

REQ-002 Elaboration SHALL fail unless IR_W == 4+3*R_ADDR_W and D_ADDR_W == 2*R_ADDR_W.

REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- Clk, in, 1: the single clock; all state changes on the rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- IM_req, out, 1: instruction fetch request.
- IM_addr, out, I_ADDR_W: fetch address.
- IM_ack, in, 1: fetch data valid.
- IM_data, in, IR_W: fetched instruction.
- D_addr, out, D_ADDR_W: data-memory address.
- D_wr, out, 1: data-memory write strobe.
- RF_s, out, 1: register-file write mux select; 1 = memory, 0 = ALU.
- RF_W_en, out, 1: register-file write enable.
- RF_W_addr, out, R_ADDR_W: register-file write address.
- RF_A_addr, out, R_ADDR_W: register-file read address, port A.
- RF_B_addr, out, R_ADDR_W: register-file read address, port B.
- ALU_sel, out, 4: ALU operation select.
- IR_Out, out, IR_W: instruction register.
- PC_Out, out, I_ADDR_W: program counter.
- State, out, 4: current FSM state.
- NextState, out, 4: combinational next FSM state.
- Halted, out, 1: high while in HALT.
- Illegal, out, 1: sticky flag set by an undefined opcode.

Function
REQ-004 State encoding SHALL be INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ALU=7, HALT=8; codes 9-15 SHALL go to INIT on the next edge.

REQ-005 Opcodes (IR[IR_W-1:IR_W-4]) SHALL be NOOP=0, STORE=1, LOAD=2, ADD=3, SUB=4, HALT=5; opcodes 6-15 are undefined.

REQ-006 Instruction fields SHALL be decoded as follows:
- STORE: A = IR[3R-1:2R], D = IR[2R-1:0].
- LOAD: D = IR[3R-1:R], W = IR[R-1:0].
- ADD/SUB: A = IR[3R-1:2R], B = IR[2R-1:R], W = IR[R-1:0].
- Here R = R_ADDR_W.

REQ-007 INIT SHALL go to FETCH unconditionally.

REQ-008 FETCH SHALL assert IM_req with IM_addr = PC and hold both stable until IM_ack; FETCH SHALL not time out.

REQ-009 On the edge where FETCH and IM_ack are both high, the block SHALL set IR <= IM_data, set PC <= PC+1 (modulo 2^I_ADDR_W, so all-ones wraps to 0), and go to DECODE.

REQ-010 DECODE SHALL branch on opcode: 0 -> NOOP, 1 -> STORE, 2 -> LOAD_A, 3/4 -> ALU, 5 -> HALT, undefined -> NOOP with Illegal set.

REQ-011 LOAD_A SHALL drive D_addr, RF_s=1 and RF_W_addr with RF_W_en=0, then go to LOAD_B.

REQ-012 LOAD_B SHALL hold the LOAD_A values with RF_W_en=1, then go to FETCH.

REQ-013 STORE SHALL drive D_addr and RF_A_addr with D_wr=1 for exactly one cycle, then go to FETCH.

REQ-014 ALU SHALL drive RF_A_addr, RF_B_addr, RF_W_addr, RF_s=0, RF_W_en=1 and ALU_sel (ADD=4'd1, SUB=4'd2) for one cycle, then go to FETCH.

REQ-015 NOOP SHALL go to FETCH.

REQ-016 HALT SHALL stay in HALT with Halted=1 and all strobes low until Reset.

REQ-017 In every state not named above for a signal, D_wr, RF_W_en, IM_req and RF_s SHALL be 0, ALU_sel SHALL be 0, and all address outputs SHALL be 0.

REQ-018 Per-instruction latency SHALL be counted from the IM_ack edge: NOOP 2 cycles, STORE 2, ALU 2, LOAD 3.

REQ-019 D_wr and RF_W_en SHALL never be high in the same cycle.

REQ-020 NextState SHALL equal the value State takes on the next edge when Reset is low.

REQ-021 An IM_ack outside FETCH SHALL be ignored.

Reset
REQ-022 Reset high SHALL immediately force State=INIT, PC=0, IR=0 and Illegal=0, with all outputs at their REQ-017 values, independent of Clk.

REQ-023 Reset asserted mid-fetch or mid-write SHALL drop IM_req, D_wr and RF_W_en within the same cycle without waiting for IM_ack.

REQ-024 After Reset deasserts, the first rising edge SHALL move State from INIT to FETCH.

Verification
REQ-025 The bench SHALL cover at least these directed scenarios:
- Reset, IM_ack tied high, program ADD 0x3123 -> cycle sequence INIT, FETCH, DECODE, ALU; in ALU: A=1, B=2, W=3, ALU_sel=1, RF_W_en=1; PC=1.
- LOAD 0x2A57 -> in LOAD_A: D_addr=0xA5, RF_s=1, RF_W_en=0; in LOAD_B: RF_W_addr=7, RF_W_en=1.
- STORE 0x14C8 with IM_ack delayed 3 cycles -> IM_req and IM_addr held for 4 cycles, then D_addr=0xC8, RF_A_addr=4, D_wr high for exactly 1 cycle.
- PC=0x7F with NOOP 0x0000 -> PC wraps to 0x00; undefined opcode 0xF000 -> Illegal=1, flow continues to FETCH.
- HALT 0x5000 -> Halted=1 indefinitely, IM_req=0; asserting Reset clears Halted and PC asynchronously.
- Reset asserted during the LOAD_B cycle -> RF_W_en falls before the next Clk edge; State=0.
